mem_perf_counter: RTL and testbench
===================================

MEM_PERF_COUNTER -- requirements
Module: mem_perf_counter

Interface
REQ-001 SHALL have parameter PC_DATA_WIDTH, default 64: width of every counter output.
REQ-002 SHALL have parameter REQ_SIZE_WIDTH, default 16: width of the request-size field, in bytes.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 pc_clear  input  1  single-cycle pulse; zeroes all counters and flags at program start.
REQ-006 pc_freeze  input  1  level; holds all counter outputs stable while the counter dump is in progress.
REQ-007 tile_start  input  1  single-cycle pulse; a tile load/store begins.
REQ-008 tile_done  input  1  single-cycle pulse; the current tile is complete.
REQ-009 req_valid  input  1  AXI address-channel valid from the memory interface.
REQ-010 req_ready  input  1  AXI address-channel ready.
REQ-011 req_size  input  REQ_SIZE_WIDTH  bytes in the request; sampled on handshake.
REQ-012 pc_num_tiles  output  PC_DATA_WIDTH  number of completed tiles.
REQ-013 pc_tot_cycles  output  PC_DATA_WIDTH  number of cycles spent in ACTIVE.
REQ-014 pc_tot_requests  output  PC_DATA_WIDTH  number of accepted address handshakes.
REQ-015 pc_size_per_requests  output  PC_DATA_WIDTH  req_size of the first accepted request, zero-extended.
REQ-016 pc_err  output  1  sticky protocol-error flag.
REQ-017 pc_size_mismatch  output  1  sticky flag: a later request's size differs from the latched size.

Function
REQ-018 SHALL implement a two-state FSM: IDLE and ACTIVE.
REQ-019 IDLE -> ACTIVE on tile_start; ACTIVE -> IDLE on tile_done without tile_start.
REQ-020 ACTIVE with tile_done and tile_start in the same cycle: count the tile and stay ACTIVE (back-to-back tiles).
REQ-021 tile_start in ACTIVE without tile_done: ignore it and set pc_err.
REQ-022 tile_done in IDLE: ignore it and set pc_err.
REQ-023 pc_tot_cycles SHALL increment every cycle the registered state is ACTIVE; the tile_done cycle counts, the tile_start cycle does not.
REQ-024 pc_num_tiles SHALL increment on every tile_done accepted in ACTIVE.
REQ-025 pc_tot_requests SHALL increment on every cycle with req_valid and req_ready both high, regardless of FSM state.
REQ-026 On the first handshake after clear or reset, latch req_size into pc_size_per_requests.
REQ-027 On any later handshake with req_size not equal to the latched value, set pc_size_mismatch; the latched value is unchanged.
REQ-028 All counters SHALL saturate at the all-ones value and never wrap.
REQ-029 While pc_freeze is high, counters and the latched size SHALL hold, and events in those cycles are discarded.
REQ-030 While pc_freeze is high, the FSM and error flags SHALL continue to update.
REQ-031 pc_clear has priority over all events: next cycle, every counter and flag is 0, the FSM is IDLE, and the size latch is re-armed.
REQ-032 pc_clear together with tile_start leaves the FSM IDLE; the tile_start is dropped.
REQ-033 All outputs SHALL be registered; update latency is 1 cycle from the causing event.

Reset
REQ-034 On reset low at a clock edge, all outputs SHALL be 0, the FSM IDLE and the size latch armed, taking effect the same edge; reset overrides pc_clear.
REQ-035 Reset asserted mid-tile SHALL abandon the tile without counting it.

Structure
REQ-036 The FSM state enum and the default PC_DATA_WIDTH constant SHALL live in the shared genesys performance-counter package.
REQ-037 A single sub-module, sat_counter (parameterized width, with inc, clr and hold inputs), SHALL be instantiated three times.
REQ-038 One mem_perf_counter instance per buffer direction (ibuf, obuf ld/st, wbuf, bbuf, vmem1/vmem2 ld/st) SHALL feed the counter-dump block.

Verification
REQ-039 Stimulus: clear; tile_start at cycle 10, tile_done at cycle 30. Required: pc_tot_cycles=20, pc_num_tiles=1, pc_err=0.
REQ-040 Stimulus: 3 handshakes with req_size=64, then 1 with req_size=32. Required: pc_tot_requests=4, pc_size_per_requests=64, pc_size_mismatch=1.
REQ-041 Stimulus: tile_done and tile_start coincide, then tile_done 5 cycles later. Required: pc_num_tiles=2, FSM stays ACTIVE between the tiles.
REQ-042 Stimulus: pc_freeze high for 8 cycles during an ACTIVE tile with 2 handshakes. Required: counters unchanged across the freeze window.
REQ-043 Stimulus: counters preloaded near all-ones, PC_DATA_WIDTH=8, 300 ACTIVE cycles. Required: pc_tot_cycles=255 with no wrap.
REQ-044 Stimulus: reset low mid-tile, then a tile_done. Required: all outputs 0, pc_err=1 one cycle after the tile_done.

Source files
------------

// File: rtl/mem_perf_counter_pkg.sv
// rtl/mem_perf_counter_pkg.sv - shared genesys performance-counter types and defaults
package mem_perf_counter_pkg;

   localparam int PC_DATA_WIDTH_DEF = 64;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } pc_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear and hold
module sat_counter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             hold,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !hold && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/mem_perf_counter.sv
// rtl/mem_perf_counter.sv - per-buffer tile/cycle/request performance counters
module mem_perf_counter
   import mem_perf_counter_pkg::*;
#(
   parameter int PC_DATA_WIDTH  = PC_DATA_WIDTH_DEF,
   parameter int REQ_SIZE_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      pc_clear,
   input  logic                      pc_freeze,
   input  logic                      tile_start,
   input  logic                      tile_done,
   input  logic                      req_valid,
   input  logic                      req_ready,
   input  logic [REQ_SIZE_WIDTH-1:0] req_size,
   output logic [PC_DATA_WIDTH-1:0]  pc_num_tiles,
   output logic [PC_DATA_WIDTH-1:0]  pc_tot_cycles,
   output logic [PC_DATA_WIDTH-1:0]  pc_tot_requests,
   output logic [PC_DATA_WIDTH-1:0]  pc_size_per_requests,
   output logic                      pc_err,
   output logic                      pc_size_mismatch
);

   pc_state_e state_q, state_d;
   logic      tile_acc;
   logic      err_evt;
   logic      handshake;
   logic      size_armed;

   assign handshake = req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tile_acc = 1'b0;
      err_evt  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tile_start) state_d = ST_ACTIVE;
            if (tile_done)  err_evt = 1'b1;
         end
         ST_ACTIVE: begin
            // done+start together closes one tile and opens the next
            if (tile_done) begin
               tile_acc = 1'b1;
               if (!tile_start) state_d = ST_IDLE;
            end else if (tile_start) begin
               err_evt = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (pc_clear) state_d = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_err <= 1'b0;
      end else if (pc_clear) begin
         pc_err <= 1'b0;
      end else if (err_evt) begin
         pc_err <= 1'b1;
      end
   end

   // First unfrozen handshake after clear fixes the reference size
   always_ff @(posedge clk) begin
      if (!reset || pc_clear) begin
         size_armed           <= 1'b1;
         pc_size_per_requests <= '0;
         pc_size_mismatch     <= 1'b0;
      end else if (handshake && !pc_freeze) begin
         if (size_armed) begin
            size_armed           <= 1'b0;
            pc_size_per_requests <= PC_DATA_WIDTH'(req_size);
         end else if (PC_DATA_WIDTH'(req_size) != pc_size_per_requests) begin
            pc_size_mismatch <= 1'b1;
         end
      end
   end

   sat_counter #(.WIDTH(PC_DATA_WIDTH)) u_tiles (
      .clk   (clk),
      .reset (reset),
      .clr   (pc_clear),
      .hold  (pc_freeze),
      .inc   (tile_acc),
      .count (pc_num_tiles)
   );

   sat_counter #(.WIDTH(PC_DATA_WIDTH)) u_cycles (
      .clk   (clk),
      .reset (reset),
      .clr   (pc_clear),
      .hold  (pc_freeze),
      .inc   (state_q == ST_ACTIVE),
      .count (pc_tot_cycles)
   );

   sat_counter #(.WIDTH(PC_DATA_WIDTH)) u_requests (
      .clk   (clk),
      .reset (reset),
      .clr   (pc_clear),
      .hold  (pc_freeze),
      .inc   (handshake),
      .count (pc_tot_requests)
   );

endmodule

// File: tb/tb_mem_perf_counter.sv
// tb/tb_mem_perf_counter.sv - randomized and directed checks against a behavioural model
module tb_mem_perf_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, pc_clear, pc_freeze, tile_start, tile_done, req_valid, req_ready;
   logic [15:0] req_size;

   logic [63:0] num_tiles, tot_cycles, tot_requests, size_per;
   logic        err, mism;
   logic [7:0]  n8_tiles, n8_cycles, n8_requests, n8_size;
   logic        n8_err, n8_mism;

   int checks   = 0;
   int failures = 0;

   bit              m_active, m_have, m_err, m_mism;
   longint unsigned m_tiles, m_cycles, m_reqs;
   logic [15:0]     m_size;

   mem_perf_counter dut (
      .clk(clk), .reset(reset), .pc_clear(pc_clear), .pc_freeze(pc_freeze),
      .tile_start(tile_start), .tile_done(tile_done),
      .req_valid(req_valid), .req_ready(req_ready), .req_size(req_size),
      .pc_num_tiles(num_tiles), .pc_tot_cycles(tot_cycles),
      .pc_tot_requests(tot_requests), .pc_size_per_requests(size_per),
      .pc_err(err), .pc_size_mismatch(mism)
   );

   mem_perf_counter #(.PC_DATA_WIDTH(8), .REQ_SIZE_WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .pc_clear(pc_clear), .pc_freeze(pc_freeze),
      .tile_start(tile_start), .tile_done(tile_done),
      .req_valid(req_valid), .req_ready(req_ready), .req_size(req_size[7:0]),
      .pc_num_tiles(n8_tiles), .pc_tot_cycles(n8_cycles),
      .pc_tot_requests(n8_requests), .pc_size_per_requests(n8_size),
      .pc_err(n8_err), .pc_size_mismatch(n8_mism)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] sat8(input longint unsigned v);
      return (v > 255) ? 64'd255 : v;
   endfunction

   task automatic model_step();
      bit hs;
      hs = req_valid && req_ready;
      if (!reset || pc_clear) begin
         m_active = 0; m_have = 0; m_err = 0; m_mism = 0;
         m_tiles = 0; m_cycles = 0; m_reqs = 0; m_size = 0;
      end else begin
         if (!pc_freeze) begin
            if (m_active) m_cycles++;
            if (m_active && tile_done) m_tiles++;
            if (hs) begin
               m_reqs++;
               if (!m_have) begin
                  m_size = req_size;
                  m_have = 1;
               end else if (req_size != m_size) begin
                  m_mism = 1;
               end
            end
         end
         if (m_active && tile_start && !tile_done) m_err = 1;
         if (!m_active && tile_done) m_err = 1;
         if (!m_active) m_active = tile_start;
         else if (tile_done && !tile_start) m_active = 0;
      end
   endtask

   task automatic check_all();
      chk("tiles",     num_tiles,    m_tiles);
      chk("cycles",    tot_cycles,   m_cycles);
      chk("requests",  tot_requests, m_reqs);
      chk("size",      size_per,     64'(m_size));
      chk("err",       64'(err),     64'(m_err));
      chk("mismatch",  64'(mism),    64'(m_mism));
      chk("w8_tiles",  64'(n8_tiles),    sat8(m_tiles));
      chk("w8_cycles", 64'(n8_cycles),   sat8(m_cycles));
      chk("w8_reqs",   64'(n8_requests), sat8(m_reqs));
      chk("w8_size",   64'(n8_size),     64'(m_size[7:0]));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic clear_pulse();
      pc_clear = 1'b1;
      tick();
      pc_clear = 1'b0;
   endtask

   task automatic start_pulse();
      tile_start = 1'b1;
      tick();
      tile_start = 1'b0;
   endtask

   initial begin
      reset = 1'b0; pc_clear = 1'b0; pc_freeze = 1'b0; tile_start = 1'b0;
      tile_done = 1'b0; req_valid = 1'b0; req_ready = 1'b0; req_size = 16'd0;

      repeat (3) tick();
      chk("rst_cycles", tot_cycles, 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      reset = 1'b1;

      // single tile: start at cycle 10, done at cycle 30
      clear_pulse();
      repeat (9) tick();
      start_pulse();
      repeat (19) tick();
      tile_done = 1'b1; tick(); tile_done = 1'b0;
      chk("t1_cycles", tot_cycles, 64'd20);
      chk("t1_tiles", num_tiles, 64'd1);
      chk("t1_err", 64'(err), 64'd0);

      // size latch and mismatch
      clear_pulse();
      req_valid = 1'b1; req_ready = 1'b1; req_size = 16'd64;
      repeat (3) tick();
      req_size = 16'd32;
      tick();
      req_valid = 1'b0; req_ready = 1'b0;
      chk("t2_reqs", tot_requests, 64'd4);
      chk("t2_size", size_per, 64'd64);
      chk("t2_mism", 64'(mism), 64'd1);

      // back-to-back tiles
      clear_pulse();
      start_pulse();
      repeat (4) tick();
      tile_start = 1'b1; tile_done = 1'b1; tick();
      tile_start = 1'b0; tile_done = 1'b0;
      repeat (4) tick();
      tile_done = 1'b1; tick(); tile_done = 1'b0;
      chk("t3_tiles", num_tiles, 64'd2);
      chk("t3_cycles", tot_cycles, 64'd10);
      chk("t3_err", 64'(err), 64'd0);

      // freeze window with two handshakes
      clear_pulse();
      start_pulse();
      repeat (3) tick();
      pc_freeze = 1'b1; req_size = 16'd64;
      for (int i = 0; i < 8; i++) begin
         req_valid = (i == 2 || i == 5);
         req_ready = req_valid;
         tick();
         chk("t4_cycles", tot_cycles, 64'd3);
         chk("t4_reqs", tot_requests, 64'd0);
      end
      pc_freeze = 1'b0; req_valid = 1'b0; req_ready = 1'b0;
      tick();
      chk("t4_resume", tot_cycles, 64'd4);
      tile_done = 1'b1; tick(); tile_done = 1'b0;

      // saturation at 8 bits
      clear_pulse();
      start_pulse();
      repeat (300) tick();
      chk("t5_sat8", 64'(n8_cycles), 64'd255);
      chk("t5_wide", tot_cycles, 64'd300);
      tile_done = 1'b1; tick(); tile_done = 1'b0;

      // reset mid-tile, then a stray tile_done
      clear_pulse();
      start_pulse();
      repeat (5) tick();
      reset = 1'b0; tick(); reset = 1'b1;
      tile_done = 1'b1; tick(); tile_done = 1'b0;
      chk("t6_err", 64'(err), 64'd1);
      chk("t6_tiles", num_tiles, 64'd0);
      chk("t6_cycles", tot_cycles, 64'd0);

      // randomized traffic
      clear_pulse();
      req_size = 16'd64;
      for (int i = 0; i < 3000; i++) begin
         reset      = ($urandom_range(0, 299) != 0);
         pc_clear   = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 15) == 0) pc_freeze = ~pc_freeze;
         tile_start = ($urandom_range(0, 11) == 0);
         tile_done  = ($urandom_range(0, 11) == 0);
         req_valid  = $urandom_range(0, 1);
         req_ready  = $urandom_range(0, 1);
         if ($urandom_range(0, 39) == 0) req_size = 16'(16 << $urandom_range(0, 3));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
